// File: rtl/v810_bus_pkg.sv
// Shared types and constants for the v810 single-bus arbiter.
package v810_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } bus_owner_t;

    localparam logic [3:0] BEN_ALL  = 4'h0;
    localparam logic [3:0] BEN_NONE = 4'hF;

    // Bus addresses are always word aligned.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/v810_bus_prio.sv
// Grant decision between fetch and data requesters, with a bounded
// starvation counter that forces a fetch grant after repeated data grants.
module v810_bus_prio
    import v810_bus_pkg::*;
#(
    parameter int unsigned FETCH_STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ireq,
    input  logic       dreq,
    input  logic [1:0] inelig,
    input  logic       grant_en,
    output bus_owner_t grant_owner
);

    localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       fetch_ok;
    logic       data_ok;

    // inelig[0] masks the fetch requester, inelig[1] the data requester.
    always_comb begin
        fetch_ok    = ireq & ~inelig[0];
        data_ok     = dreq & ~inelig[1];
        grant_owner = NONE;
        if (grant_en) begin
            if (fetch_ok && data_ok) begin
                grant_owner = (starve_cnt_q == STARVE_MAX) ? FETCH : DATA;
            end else if (data_ok) begin
                grant_owner = DATA;
            end else if (fetch_ok) begin
                grant_owner = FETCH;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_owner == FETCH) begin
            starve_cnt_d = '0;
        end else if (grant_owner == DATA && ireq && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/v810_bus_arb.sv
// Single external-bus arbiter and cycle sequencer for the v810 fetch and
// data ports; all outputs are registered and advance only on CE.
module v810_bus_arb
    import v810_bus_pkg::*;
#(
    parameter int unsigned FETCH_STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic        IREQ,
    input  logic [31:0] IA,
    output logic [31:0] ID,
    output logic        IACK,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [31:0] DA,
    input  logic [3:0]  DBEn,
    input  logic [31:0] DWD,
    output logic [31:0] DRD,
    output logic        DACK,
    output logic [31:0] A,
    output logic [3:0]  BEn,
    output logic [31:0] D_O,
    input  logic [31:0] D_I,
    output logic        MRQn,
    output logic        RW,
    input  logic        READYn
);

    bus_state_t  state_q, state_d;
    bus_owner_t  owner_q, owner_d;
    bus_owner_t  grant_owner;
    logic [31:0] a_q, a_d;
    logic [3:0]  ben_q, ben_d;
    logic [31:0] d_o_q, d_o_d;
    logic        rw_q, rw_d;
    logic        mrqn_q, mrqn_d;
    logic        iack_q, iack_d;
    logic        dack_q, dack_d;
    logic [31:0] id_q, id_d;
    logic [31:0] drd_q, drd_d;

    logic        grant_en;
    logic [1:0]  inelig;
    logic [31:0] ld_a;
    logic [3:0]  ld_ben;
    logic [31:0] ld_do;
    logic        ld_rw;

    // In DONE the requester being acked still holds its REQ, so mask it.
    always_comb begin
        grant_en = CE && (state_q != BUS);
        inelig   = '0;
        if (state_q == DONE) begin
            inelig = {owner_q == DATA, owner_q == FETCH};
        end
    end

    v810_bus_prio #(
        .FETCH_STARVE_MAX(FETCH_STARVE_MAX)
    ) u_prio (
        .clk        (CLK),
        .rst        (RES),
        .ireq       (IREQ),
        .dreq       (DREQ),
        .inelig     (inelig),
        .grant_en   (grant_en),
        .grant_owner(grant_owner)
    );

    always_comb begin
        ld_a   = word_addr(DA);
        ld_rw  = DRW;
        ld_ben = DBEn;
        ld_do  = DRW ? '0 : DWD;
        if (grant_owner == FETCH) begin
            ld_a   = word_addr(IA);
            ld_rw  = 1'b1;
            ld_ben = BEN_ALL;
            ld_do  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        a_d     = a_q;
        ben_d   = ben_q;
        d_o_d   = d_o_q;
        rw_d    = rw_q;
        mrqn_d  = mrqn_q;
        iack_d  = 1'b0;
        dack_d  = 1'b0;
        id_d    = id_q;
        drd_d   = drd_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                    owner_d = NONE;
                end
                if (grant_owner != NONE) begin
                    state_d = BUS;
                    owner_d = grant_owner;
                    a_d     = ld_a;
                    ben_d   = ld_ben;
                    d_o_d   = ld_do;
                    rw_d    = ld_rw;
                    mrqn_d  = 1'b0;
                end
            end
            BUS: begin
                if (!READYn) begin
                    state_d = DONE;
                    mrqn_d  = 1'b1;
                    if (owner_q == FETCH) begin
                        iack_d = 1'b1;
                        id_d   = D_I;
                    end else if (owner_q == DATA) begin
                        dack_d = 1'b1;
                        if (rw_q) begin
                            drd_d = D_I;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With CE low every register holds, which also stretches an ACK in DONE.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= IDLE;
            owner_q <= NONE;
            a_q     <= '0;
            ben_q   <= BEN_NONE;
            d_o_q   <= '0;
            rw_q    <= 1'b1;
            mrqn_q  <= 1'b1;
            iack_q  <= 1'b0;
            dack_q  <= 1'b0;
            id_q    <= '0;
            drd_q   <= '0;
        end else if (CE) begin
            state_q <= state_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            ben_q   <= ben_d;
            d_o_q   <= d_o_d;
            rw_q    <= rw_d;
            mrqn_q  <= mrqn_d;
            iack_q  <= iack_d;
            dack_q  <= dack_d;
            id_q    <= id_d;
            drd_q   <= drd_d;
        end
    end

    assign A    = a_q;
    assign BEn  = ben_q;
    assign D_O  = d_o_q;
    assign RW   = rw_q;
    assign MRQn = mrqn_q;
    assign IACK = iack_q;
    assign DACK = dack_q;
    assign ID   = id_q;
    assign DRD  = drd_q;

endmodule

// File: tb/tb_v810_bus_arb.sv
// Randomised bench for v810_bus_arb: transaction-level arbitration model,
// memory responder with wait states, and per-scenario checks.
module tb_v810_bus_arb;

    localparam int unsigned STARVE = 4;

    logic        CLK = 1'b0;
    logic        RES, CE, IREQ, DREQ, DRW, READYn;
    logic [31:0] IA, DA, DWD, D_I;
    logic [3:0]  DBEn;
    logic [31:0] ID, DRD, A, D_O;
    logic        IACK, DACK, MRQn, RW;
    logic [3:0]  BEn;

    always #5 CLK = ~CLK;

    v810_bus_arb #(.FETCH_STARVE_MAX(STARVE)) dut (
        .CLK(CLK), .RES(RES), .CE(CE),
        .IREQ(IREQ), .IA(IA), .ID(ID), .IACK(IACK),
        .DREQ(DREQ), .DRW(DRW), .DA(DA), .DBEn(DBEn), .DWD(DWD), .DRD(DRD), .DACK(DACK),
        .A(A), .BEn(BEn), .D_O(D_O), .D_I(D_I), .MRQn(MRQn), .RW(RW), .READYn(READYn)
    );

    typedef struct {
        bit          is_data;
        bit          rw;
        logic [31:0] addr;
        logic [3:0]  ben;
        logic [31:0] wd;
        int unsigned waits;
    } op_t;

    typedef struct {
        op_t         op;
        int unsigned grant_e;
        int unsigned ack_e;
        logic [31:0] rdata;
    } exp_t;

    op_t         fops[$];
    op_t         dops[$];
    exp_t        expq[$];
    int unsigned sf, sd;
    int unsigned model_cnt;
    logic [31:0] mem[256];
    logic [31:0] model_mem[256];
    logic [31:0] drd_exp;
    int unsigned mrq_low;
    int          errors = 0;
    int          checks = 0;

    function automatic op_t mk(bit is_data, bit rw, logic [31:0] addr, logic [3:0] ben,
                               logic [31:0] wd, int unsigned w);
        op_t o;
        o.is_data = is_data;
        o.rw      = is_data ? rw : 1'b1;
        o.addr    = addr;
        o.ben     = is_data ? ben : 4'h0;
        o.wd      = wd;
        o.waits   = w;
        return o;
    endfunction

    function automatic op_t rnd_op(bit is_data);
        return mk(is_data, 1'($urandom), $urandom & 32'h3FF, 4'($urandom), $urandom,
                  $urandom_range(3, 0));
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] ben, logic [31:0] wd);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (!ben[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Abstract schedule: a grant at edge t occupies the bus for 1+w edges,
    // acks at t+1+w and the next decision is at t+2+w with the acked side masked.
    task automatic build_model();
        int unsigned fi = 0, di = 0, t = 1;
        int          excl = 0;
        bit          ireq_lvl, ip, dp, pick_d;
        op_t         o;
        exp_t        x;
        expq.delete();
        model_mem = mem;
        while (fi < fops.size() || di < dops.size()) begin
            ireq_lvl = (fi < fops.size()) && (t >= sf);
            ip = ireq_lvl && excl != 1;
            dp = (di < dops.size()) && (t >= sd) && excl != 2;
            if (!ip && !dp) begin
                excl = 0;
                t++;
                continue;
            end
            pick_d = dp && !(ip && model_cnt == STARVE);
            if (pick_d) begin
                o = dops[di];
                di++;
                if (ireq_lvl && model_cnt < STARVE) model_cnt++;
            end else begin
                o = fops[fi];
                fi++;
                model_cnt = 0;
            end
            x.op = o;
            x.grant_e = t;
            x.ack_e = t + 1 + o.waits;
            x.rdata = model_mem[o.addr[9:2]];
            if (!o.rw) model_mem[o.addr[9:2]] = merge(model_mem[o.addr[9:2]], o.ben, o.wd);
            expq.push_back(x);
            excl = pick_d ? 2 : 1;
            t = t + 2 + o.waits;
        end
    endtask

    task automatic run_scenario(input string name, input bit ce_toggle);
        int unsigned fi = 0, di = 0, bi = 0, acks = 0, ce_edges = 0, ws_left = 0, cyc = 0;
        int unsigned budget;
        bit          prev_mrqn = 1'b1, ce_prev, mem_ok;
        exp_t        cur;
        logic [31:0] exp_a, exp_do;
        build_model();
        mrq_low = 0;
        READYn = 1'b1;
        budget = (expq.size() == 0) ? 4 : 2 * expq[expq.size()-1].ack_e + 20;
        cur = '{default: '0};
        while (acks < expq.size() && cyc < budget) begin
            CE = ce_toggle ? (cyc % 2 == 0) : 1'b1;
            IREQ = (fi < fops.size()) && (ce_edges + 1 >= sf);
            if (fi < fops.size()) IA = fops[fi].addr;
            DREQ = (di < dops.size()) && (ce_edges + 1 >= sd);
            if (di < dops.size()) begin
                DA = dops[di].addr; DRW = dops[di].rw; DBEn = dops[di].ben; DWD = dops[di].wd;
            end
            @(posedge CLK); #1;
            cyc++;
            ce_prev = CE;
            if (CE) ce_edges++;
            if (MRQn == 1'b0 && ce_prev) mrq_low++;
            exp_a  = cur.op.addr & 32'hFFFF_FFFC;
            exp_do = (cur.op.is_data && !cur.op.rw) ? cur.op.wd : 32'h0;
            if (MRQn == 1'b0 && prev_mrqn) begin
                checks++;
                if (bi >= expq.size()) begin
                    errors++;
                    $display("FAIL %s bus_start: unexpected bus cycle at edge %0d, required none", name, ce_edges);
                end else begin
                    cur = expq[bi];
                    bi++;
                    ws_left = cur.op.waits;
                    exp_a  = cur.op.addr & 32'hFFFF_FFFC;
                    exp_do = (cur.op.is_data && !cur.op.rw) ? cur.op.wd : 32'h0;
                    if (ce_edges != cur.grant_e || A !== exp_a || RW !== cur.op.rw ||
                        BEn !== cur.op.ben || D_O !== exp_do) begin
                        errors++;
                        $display("FAIL %s bus_start: edge=%0d A=%h RW=%b BEn=%h D_O=%h, required edge=%0d A=%h RW=%b BEn=%h D_O=%h",
                                 name, ce_edges, A, RW, BEn, D_O, cur.grant_e, exp_a, cur.op.rw, cur.op.ben, exp_do);
                    end
                end
            end else if (MRQn == 1'b0) begin
                if (ce_prev && ws_left > 0) ws_left--;
                checks++;
                if (A !== exp_a || RW !== cur.op.rw || BEn !== cur.op.ben || D_O !== exp_do) begin
                    errors++;
                    $display("FAIL %s bus_hold: A=%h RW=%b BEn=%h D_O=%h, required A=%h RW=%b BEn=%h D_O=%h",
                             name, A, RW, BEn, D_O, exp_a, cur.op.rw, cur.op.ben, exp_do);
                end
            end
            if (IACK === 1'b1 && ce_prev) begin
                checks++;
                acks++;
                fi++;
                if (cur.op.is_data || ce_edges != cur.ack_e || ID !== cur.rdata || DACK !== 1'b0) begin
                    errors++;
                    $display("FAIL %s iack: edge=%0d ID=%h DACK=%b data_owner=%b, required edge=%0d ID=%h DACK=0 data_owner=0",
                             name, ce_edges, ID, DACK, cur.op.is_data, cur.ack_e, cur.rdata);
                end
            end
            if (DACK === 1'b1 && ce_prev) begin
                checks++;
                acks++;
                di++;
                if (cur.op.rw) drd_exp = cur.rdata;
                if (!cur.op.is_data || ce_edges != cur.ack_e || DRD !== drd_exp) begin
                    errors++;
                    $display("FAIL %s dack: edge=%0d DRD=%h data_owner=%b, required edge=%0d DRD=%h data_owner=1",
                             name, ce_edges, DRD, cur.op.is_data, cur.ack_e, drd_exp);
                end
            end
            prev_mrqn = MRQn;
            if (MRQn == 1'b0 && ws_left == 0 && RW == 1'b0) mem[A[9:2]] = merge(mem[A[9:2]], BEn, D_O);
            READYn = !(MRQn == 1'b0 && ws_left == 0);
            D_I = mem[A[9:2]];
        end
        checks++;
        if (acks != expq.size() || bi != expq.size()) begin
            errors++;
            $display("FAIL %s completion: acks=%0d bus_cycles=%0d, required %0d of each within %0d cycles",
                     name, acks, bi, expq.size(), budget);
        end
        IREQ = 1'b0; DREQ = 1'b0; CE = 1'b1; READYn = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        checks++;
        if (MRQn !== 1'b1 || IACK !== 1'b0 || DACK !== 1'b0) begin
            errors++;
            $display("FAIL %s quiesce: MRQn=%b IACK=%b DACK=%b, required 1 0 0", name, MRQn, IACK, DACK);
        end
        mem_ok = 1'b1;
        for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) mem_ok = 1'b0;
        checks++;
        if (!mem_ok) begin
            errors++;
            $display("FAIL %s memory_image: bus writes differ from model, required identical", name);
        end
    endtask

    task automatic test_reset();
        RES = 1'b1; CE = 1'b1; IREQ = 1'b0; DREQ = 1'b0; DRW = 1'b1;
        IA = '0; DA = '0; DBEn = '1; DWD = '0; D_I = '0; READYn = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (MRQn !== 1'b1 || RW !== 1'b1 || BEn !== 4'hF) begin
            errors++;
            $display("FAIL reset_ctrl: MRQn=%b RW=%b BEn=%h, required 1 1 f", MRQn, RW, BEn);
        end
        checks++;
        if (A !== 32'h0 || D_O !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: A=%h D_O=%h, required 0 0", A, D_O);
        end
        checks++;
        if (IACK !== 1'b0 || DACK !== 1'b0 || ID !== 32'h0 || DRD !== 32'h0) begin
            errors++;
            $display("FAIL reset_acks: IACK=%b DACK=%b ID=%h DRD=%h, required 0 0 0 0", IACK, DACK, ID, DRD);
        end
        RES = 1'b0;
        drd_exp = '0;
        model_cnt = 0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (MRQn !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: MRQn=%b with no requests, required 1", MRQn);
        end
    endtask

    task automatic test_single_fetch();
        fops.delete(); dops.delete(); sf = 1; sd = 1;
        fops.push_back(mk(1'b0, 1'b1, 32'h104, 4'h0, 32'h0, 0));
        run_scenario("single_fetch", 1'b0);
        checks++;
        if (mrq_low != 1 || ID !== mem[32'h104 >> 2]) begin
            errors++;
            $display("FAIL single_fetch_summary: mrq_low=%0d ID=%h, required 1 %h", mrq_low, ID, mem[32'h104 >> 2]);
        end
    endtask

    task automatic test_simultaneous(input bit ce_toggle);
        fops.delete(); dops.delete(); sf = 1; sd = 1;
        fops.push_back(mk(1'b0, 1'b1, 32'h300, 4'h0, 32'h0, 0));
        dops.push_back(mk(1'b1, 1'b1, 32'h200, 4'h0, 32'h0, 0));
        run_scenario(ce_toggle ? "ce_toggle" : "simultaneous", ce_toggle);
        checks++;
        if (mrq_low != 2 || ID !== mem[32'h300 >> 2] || DRD !== mem[32'h200 >> 2]) begin
            errors++;
            $display("FAIL %s_summary: mrq_low=%0d ID=%h DRD=%h, required 2 %h %h", ce_toggle ? "ce_toggle" : "simultaneous",
                     mrq_low, ID, DRD, mem[32'h300 >> 2], mem[32'h200 >> 2]);
        end
    endtask

    task automatic test_write_waits();
        fops.delete(); dops.delete(); sf = 1; sd = 1;
        dops.push_back(mk(1'b1, 1'b0, 32'h70, 4'h0, 32'd9, 3));
        run_scenario("write_waits", 1'b0);
        checks++;
        if (mrq_low != 4 || mem[32'h70 >> 2] !== 32'd9) begin
            errors++;
            $display("FAIL write_waits_summary: mrq_low=%0d mem=%h, required 4 00000009", mrq_low, mem[32'h70 >> 2]);
        end
    endtask

    task automatic test_back_to_back();
        fops.delete(); dops.delete(); sf = 1; sd = 1;
        for (int i = 0; i < 5; i++) fops.push_back(rnd_op(1'b0));
        for (int i = 0; i < 8; i++) dops.push_back(rnd_op(1'b1));
        run_scenario("back_to_back", 1'b0);
    endtask

    task automatic test_random(input int unsigned n);
        for (int s = 0; s < int'(n); s++) begin
            fops.delete(); dops.delete();
            sf = $urandom_range(4, 1);
            sd = $urandom_range(4, 1);
            for (int i = 0; i < int'($urandom_range(4, 1)); i++) fops.push_back(rnd_op(1'b0));
            for (int i = 0; i < int'($urandom_range(4, 0)); i++) dops.push_back(rnd_op(1'b1));
            run_scenario("random", 1'($urandom));
        end
    endtask

    task automatic test_reset_abort();
        int n = 0;
        CE = 1'b1; READYn = 1'b1; IA = 32'h40; IREQ = 1'b1;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (MRQn !== 1'b0 && n < 8);
        checks++;
        if (MRQn !== 1'b0) begin
            errors++;
            $display("FAIL abort_setup: MRQn=%b after %0d cycles, required 0", MRQn, n);
        end
        #2 RES = 1'b1;
        #1;
        checks++;
        if (MRQn !== 1'b1 || RW !== 1'b1 || BEn !== 4'hF || A !== 32'h0 || D_O !== 32'h0) begin
            errors++;
            $display("FAIL abort_async: MRQn=%b RW=%b BEn=%h A=%h D_O=%h, required 1 1 f 0 0", MRQn, RW, BEn, A, D_O);
        end
        @(posedge CLK); #1;
        IREQ = 1'b0;
        RES = 1'b0;
        drd_exp = '0;
        model_cnt = 0;
        repeat (4) begin
            @(posedge CLK); #1;
            checks++;
            if (IACK !== 1'b0 || DACK !== 1'b0 || MRQn !== 1'b1 || ID !== 32'h0) begin
                errors++;
                $display("FAIL abort_no_ack: IACK=%b DACK=%b MRQn=%b ID=%h, required 0 0 1 0", IACK, DACK, MRQn, ID);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_single_fetch();
        test_simultaneous(1'b0);
        test_write_waits();
        test_back_to_back();
        test_simultaneous(1'b1);
        test_random(8);
        test_reset_abort();
        test_random(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
